// File: rtl/sp_ram_multibank_wrap.sv
// sp_ram_multibank_wrap
//   Single-port RAM wrapper with a request/grant/rvalid handshake in front of
//   NUM_BANKS word-interleaved banks. After reset the wrapper can zero every
//   row (one row of all banks per cycle) before it starts granting requests.
//   Reads return READ_LATENCY cycles after the grant, fully pipelined, in order.
//
// Optional build macro: SP_RAM_PARITY_EN
//   Adds one even-parity bit per byte to every stored word. The parity is
//   checked in the stage that drives rvalid_o and flagged on err_o.
//   When the macro is undefined, err_o is tied low.
//
// Ports
//   clk          clock, rising edge
//   rstn_i       asynchronous active-low reset
//   en_i         request valid
//   gnt_o        request accepted this cycle (en_i while READY)
//   addr_i       byte address (sub-word bits ignored)
//   wdata_i      write data
//   we_i         1 = write, 0 = read
//   be_i         write byte enables
//   bypass_en_i  accept writes without updating the array
//   rdata_o      read data, held between rvalid_o pulses
//   rvalid_o     one-cycle read data valid
//   init_busy_o  zero-initialisation in progress
//   err_o        parity error on the current rvalid_o
//
// state | meaning
// RST   | first cycle after reset release
// INIT  | writing zero to row init_row_q of every bank
// READY | serving requests until the next reset
module sp_ram_multibank_wrap #(
  parameter int RAM_SIZE     = 32768,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_BANKS    = 4,
  parameter int READ_LATENCY = 1,
  parameter int INIT_ZERO    = 1,
  parameter int ADDR_WIDTH   = $clog2(RAM_SIZE)
) (
  input  logic                    clk,
  input  logic                    rstn_i,
  input  logic                    en_i,
  output logic                    gnt_o,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic                    bypass_en_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    rvalid_o,
  output logic                    init_busy_o,
  output logic                    err_o
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int OFF    = $clog2(NBYTES);
  localparam int DEPTH  = RAM_SIZE / (NUM_BANKS * NBYTES);
  localparam int ROW_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int WA_W   = ADDR_WIDTH - OFF;
`ifdef SP_RAM_PARITY_EN
  localparam int PAR_W  = NBYTES;
`else
  localparam int PAR_W  = 0;
`endif
  // Stored word: data in the low bits, per-byte parity (if any) above it.
  localparam int EW     = DATA_WIDTH + PAR_W;

  localparam logic [1:0] ST_RST   = 2'd0;
  localparam logic [1:0] ST_INIT  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ROW_W-1:0]  init_row_q, init_row_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [BANK_W-1:0] tag_q, tag_d;
  logic [EW-1:0]     bank_rd_q [NUM_BANKS];
  logic [EW-1:0]     bank_rd_d [NUM_BANKS];
  logic [EW-1:0]     mem [NUM_BANKS][DEPTH];

  logic [WA_W-1:0]   wa;
  logic [BANK_W-1:0] bank_sel;
  logic [ROW_W-1:0]  row_sel;
  logic              wr_acc, rd_acc;
  logic [EW-1:0]     s0_word, out_word;

  assign wa       = addr_i[ADDR_WIDTH-1:OFF];
  assign bank_sel = BANK_W'(wa % NUM_BANKS);
  assign row_sel  = ROW_W'(wa / NUM_BANKS);

  generate
    if (OFF > 0) begin : g_lsb
      logic unused_addr_lsb;
      assign unused_addr_lsb = ^addr_i[OFF-1:0];
    end
  endgenerate

  assign gnt_o       = en_i && (state_q == ST_READY);
  assign wr_acc      = gnt_o && we_i && !bypass_en_i;
  assign rd_acc      = gnt_o && !we_i;
  assign init_busy_o = (state_q == ST_INIT);

  always_comb begin
    state_d    = state_q;
    init_row_d = init_row_q;
    case (state_q)
      ST_RST: begin
        init_row_d = '0;
        state_d    = (INIT_ZERO != 0) ? ST_INIT : ST_READY;
      end
      ST_INIT: begin
        if (init_row_q == ROW_W'(DEPTH - 1)) state_d = ST_READY;
        init_row_d = init_row_q + ROW_W'(1);
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_RST;
    endcase
  end

  // Array: no reset, the zero-init engine owns its contents after reset.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      for (int b = 0; b < NUM_BANKS; b++) mem[b][init_row_q] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (be_i[i]) begin
          mem[bank_sel][row_sel][8*i +: 8] <= wdata_i[8*i +: 8];
`ifdef SP_RAM_PARITY_EN
          mem[bank_sel][row_sel][DATA_WIDTH+i] <= ^wdata_i[8*i +: 8];
`endif
        end
      end
    end
  end

  // Each bank has its own read register (macro output); the bank tag picks
  // which one feeds the return pipeline. Registers only move on a read of
  // their own bank, so the selected value holds between reads.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) bank_rd_d[b] = bank_rd_q[b];
    if (rd_acc) bank_rd_d[bank_sel] = mem[bank_sel][row_sel];
    tag_d    = rd_acc ? bank_sel : tag_q;
    vld_d[0] = rd_acc;
    for (int i = 1; i < READ_LATENCY; i++) vld_d[i] = vld_q[i-1];
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_RST;
      init_row_q <= '0;
      vld_q      <= '0;
      tag_q      <= '0;
      for (int b = 0; b < NUM_BANKS; b++) bank_rd_q[b] <= '0;
    end else begin
      state_q    <= state_d;
      init_row_q <= init_row_d;
      vld_q      <= vld_d;
      tag_q      <= tag_d;
      bank_rd_q  <= bank_rd_d;
    end
  end

  assign s0_word = bank_rd_q[tag_q];

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign out_word = s0_word;
    end else begin : g_pipe
      logic [EW-1:0] pipe_q [READ_LATENCY-1];
      logic [EW-1:0] pipe_d [READ_LATENCY-1];
      // Stages load only behind a valid read, so the last stage holds rdata_o.
      always_comb begin
        for (int i = 0; i < READ_LATENCY-1; i++) pipe_d[i] = pipe_q[i];
        if (vld_q[0]) pipe_d[0] = s0_word;
        for (int i = 1; i < READ_LATENCY-1; i++) begin
          if (vld_q[i]) pipe_d[i] = pipe_q[i-1];
        end
      end
      always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
          for (int i = 0; i < READ_LATENCY-1; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q <= pipe_d;
        end
      end
      assign out_word = pipe_q[READ_LATENCY-2];
    end
  endgenerate

  assign rvalid_o = vld_q[READ_LATENCY-1];
  assign rdata_o  = out_word[DATA_WIDTH-1:0];

`ifdef SP_RAM_PARITY_EN
  always_comb begin
    err_o = 1'b0;
    for (int i = 0; i < NBYTES; i++) begin
      if (out_word[DATA_WIDTH+i] != ^out_word[8*i +: 8]) err_o = rvalid_o;
    end
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sp_ram_multibank_wrap.sv
module tb_sp_ram_multibank_wrap;
  localparam int AW       = 10;
  localparam int RL       = 2;
  localparam int WORDS    = 256;
  localparam int INIT_CYC = 64;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0, we = 1'b0, bypass = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;
  logic        gnt, rvalid, busy, err;
  logic [31:0] rdata;

  sp_ram_multibank_wrap #(
    .RAM_SIZE(1024), .DATA_WIDTH(32), .NUM_BANKS(4),
    .READ_LATENCY(RL), .INIT_ZERO(1), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rstn_i(rstn), .en_i(en), .gnt_o(gnt), .addr_i(addr),
    .wdata_i(wdata), .we_i(we), .be_i(be), .bypass_en_i(bypass),
    .rdata_o(rdata), .rvalid_o(rvalid), .init_busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: flat word array, edge count since reset release,
  // and a queue of pending read returns stamped with their due edge.
  typedef struct {
    int          due;
    logic [31:0] data;
    bit          bad;
  } rd_t;

  logic [31:0] mdl_mem [WORDS];
  bit          mdl_bad [WORDS];
  int          n_edges = 0;
  rd_t         rq [$];
  rd_t         m_e;
  int          m_wa;
  logic        exp_rvalid = 1'b0, exp_err = 1'b0;
  logic [31:0] exp_rdata = '0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      n_edges = 0;
      rq.delete();
      exp_rvalid = 1'b0;
      exp_err = 1'b0;
      exp_rdata = '0;
    end else begin
      if (en && n_edges >= INIT_CYC + 1) begin
        m_wa = int'(addr) >> 2;
        if (we) begin
          if (!bypass)
            for (int i = 0; i < 4; i++)
              if (be[i]) mdl_mem[m_wa][8*i +: 8] = wdata[8*i +: 8];
        end else begin
          m_e.due  = n_edges + RL;
          m_e.data = mdl_mem[m_wa];
          m_e.bad  = mdl_bad[m_wa];
          rq.push_back(m_e);
        end
      end
      n_edges++;
      if (n_edges == INIT_CYC)
        for (int w = 0; w < WORDS; w++) begin
          mdl_mem[w] = '0;
          mdl_bad[w] = 1'b0;
        end
      exp_rvalid = 1'b0;
      exp_err = 1'b0;
      if (rq.size() > 0 && rq[0].due == n_edges) begin
        exp_rvalid = 1'b1;
        exp_rdata  = rq[0].data;
        exp_err    = rq[0].bad;
        void'(rq.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    chk("gnt", gnt, en && (n_edges >= INIT_CYC + 1));
    chk("init_busy", busy, (n_edges >= 1) && (n_edges <= INIT_CYC));
    chk("rvalid", rvalid, exp_rvalid);
    chk("rdata", rdata, exp_rdata);
    chk("err", err, exp_rvalid && exp_err);
  end

  // Read-return log for the directed literal checks.
  int          cyc = 0;
  logic [31:0] rv_data [$];
  int          rv_cyc [$];
  logic        rv_err [$];
  always @(posedge clk) cyc++;
  always @(negedge clk)
    if (rvalid) begin
      rv_data.push_back(rdata);
      rv_cyc.push_back(cyc);
      rv_err.push_back(err);
    end

  task automatic clear_log();
    rv_data.delete();
    rv_cyc.delete();
    rv_err.delete();
  endtask

  // Called just after a rising edge; returns just after the grant edge.
  task automatic req(input bit w, input logic [AW-1:0] a, input logic [31:0] d,
                     input logic [3:0] b, input bit byp, output int gcyc);
    bit done = 1'b0;
    en = 1'b1; we = w; addr = a; wdata = d; be = b; bypass = byp;
    gcyc = -1;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (gnt) begin
        done = 1'b1;
        gcyc = cyc;
      end
      @(posedge clk);
      #1;
    end
    en = 1'b0; we = 1'b0; bypass = 1'b0;
    chk("req_granted", done, 1'b1);
  endtask

  task automatic wait_rv(input int n);
    int k = 0;
    while (rv_data.size() < n && k < 50) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("rvalid_count", rv_data.size() >= n, 1'b1);
  endtask

  task automatic count_busy(input string name, input int stop_at, output int cnt);
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (busy) cnt++;
      if (gnt || (stop_at > 0 && cnt == stop_at)) break;
      if (!busy && cnt > 0) break;
    end
    if (stop_at == 0) chk(name, cnt, INIT_CYC);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  int g, bc;

  initial begin
    // Reset, then hold a read of the top word through the whole init.
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    en = 1'b1; we = 1'b0; addr = 10'h3FC;
    clear_log();
    count_busy("init_cycles", 0, bc);
    @(posedge clk);
    #1;
    en = 1'b0;
    wait_rv(1);
    if (rv_data.size() > 0) chk("read_3fc_zero", rv_data[0], 32'h0);

    // Byte-enable merge and read latency.
    clear_log();
    req(1'b1, 10'h010, 32'hDEADBEEF, 4'hF, 1'b0, g);
    req(1'b1, 10'h010, 32'h00005500, 4'b0010, 1'b0, g);
    req(1'b0, 10'h010, 32'h0, 4'h0, 1'b0, g);
    wait_rv(1);
    if (rv_data.size() > 0) begin
      chk("merge_data", rv_data[0], 32'hDEAD55EF);
      chk("read_latency", rv_cyc[0] - g, RL);
    end

    // One word in each bank, then four back-to-back reads.
    req(1'b1, 10'h000, 32'h11, 4'hF, 1'b0, g);
    req(1'b1, 10'h004, 32'h22, 4'hF, 1'b0, g);
    req(1'b1, 10'h008, 32'h33, 4'hF, 1'b0, g);
    req(1'b1, 10'h00C, 32'h44, 4'hF, 1'b0, g);
    clear_log();
    for (int i = 0; i < 4; i++) req(1'b0, AW'(4 * i), 32'h0, 4'h0, 1'b0, g);
    wait_rv(4);
    if (rv_data.size() >= 4) begin
      chk("b2b_0", rv_data[0], 32'h11);
      chk("b2b_1", rv_data[1], 32'h22);
      chk("b2b_2", rv_data[2], 32'h33);
      chk("b2b_3", rv_data[3], 32'h44);
      chk("b2b_consecutive", rv_cyc[3] - rv_cyc[0], 3);
    end

    // Bypassed write is granted but leaves the array alone.
    req(1'b1, 10'h020, 32'h12345678, 4'hF, 1'b0, g);
    req(1'b1, 10'h020, 32'hCAFE0000, 4'hF, 1'b1, g);
    chk("bypass_granted", g >= 0, 1'b1);
    clear_log();
    req(1'b0, 10'h020, 32'h0, 4'h0, 1'b0, g);
    wait_rv(1);
    if (rv_data.size() > 0) chk("bypass_readback", rv_data[0], 32'h12345678);

    // Reset with two reads in flight: no return may appear.
    clear_log();
    req(1'b0, 10'h010, 32'h0, 4'h0, 1'b0, g);
    en = 1'b1; we = 1'b0; addr = 10'h000;
    @(posedge clk);
    rstn = 1'b0;
    en = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    count_busy("init_after_flush", 0, bc);
    chk("flush_no_rvalid", rv_data.size(), 0);

    // Reset again while init is on row 30; init restarts from row 0.
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    count_busy("", 31, bc);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    count_busy("init_restart", 0, bc);
    @(posedge clk);
    #1;

    // Randomized traffic with one reset pulse in the middle.
    for (int k = 0; k < 3000; k++) begin
      en     = ($urandom_range(0, 3) != 0);
      we     = $urandom_range(0, 1);
      addr   = AW'($urandom);
      wdata  = $urandom;
      be     = 4'($urandom);
      bypass = ($urandom_range(0, 7) == 0);
      if (k == 1500) rstn = 1'b0;
      if (k == 1502) rstn = 1'b1;
      @(posedge clk);
      #1;
    end
    en = 1'b0; we = 1'b0; bypass = 1'b0;
    repeat (5) @(posedge clk);
    #1;

`ifdef SP_RAM_PARITY_EN
    req(1'b1, 10'h040, 32'hA5A5A5A5, 4'hF, 1'b0, g);
    req(1'b1, 10'h044, 32'h0F0F0F0F, 4'hF, 1'b0, g);
    dut.mem[0][4][3] = ~dut.mem[0][4][3];
    mdl_mem[16] = mdl_mem[16] ^ 32'h8;
    mdl_bad[16] = 1'b1;
    clear_log();
    req(1'b0, 10'h040, 32'h0, 4'h0, 1'b0, g);
    req(1'b0, 10'h044, 32'h0, 4'h0, 1'b0, g);
    wait_rv(2);
    if (rv_data.size() >= 2) begin
      chk("par_data", rv_data[0], 32'hA5A5A5AD);
      chk("par_err", rv_err[0], 1'b1);
      chk("par_clean_err", rv_err[1], 1'b0);
    end
    repeat (3) @(posedge clk);
    #1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
